qei_velocity: RTL and testbench

QEI_VELOCITY -- requirements
Module: qei_velocity

---
 rtl/qei_velocity.sv | 155 +++++++++++++++
 tb/tb_qei_velocity.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/qei_velocity.sv
// qei_velocity: turns the per-count step/dir pulses of a quadrature decoder
// into a gated velocity (net count per GATE_CYCLES window) and a step period
// (cycles between consecutive same-direction steps), with a stopped flag.
module qei_velocity #(
    parameter int GATE_CYCLES = 1024,
    parameter int VW          = 16,
    parameter int PW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          step,
    input  logic          dir,
    output logic [VW-1:0] vel,
    output logic          vel_valid,
    output logic [PW-1:0] period,
    output logic          period_valid,
    output logic          stopped
);

    localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;

    localparam logic [VW-1:0] VMAX     = {1'b0, {(VW-1){1'b1}}};
    localparam logic [VW-1:0] VMIN     = {1'b1, {(VW-1){1'b0}}};
    localparam logic [PW-1:0] PMAX     = {PW{1'b1}};
    localparam logic [GW-1:0] GATE_END = GW'(GATE_CYCLES - 1);

    // Saturating +1/-1 update of the signed window count.
    function automatic logic [VW-1:0] sat_step(
        input logic [VW-1:0] a,
        input logic          s,
        input logic          d
    );
        logic [VW-1:0] r;
        r = a;
        if (!s) begin
            r = a;
        end else if (d) begin
            if (a == VMAX) r = a;
            else           r = a + VW'(1);
        end else begin
            if (a == VMIN) r = a;
            else           r = a - VW'(1);
        end
        return r;
    endfunction

    logic [GW-1:0] gcnt_r,  gcnt_s;
    logic [VW-1:0] acc_r,   acc_s;
    logic [VW-1:0] vel_r,   vel_s;
    logic          vv_r,    vv_s;
    logic [PW-1:0] pcnt_r,  pcnt_s;
    logic [PW-1:0] per_r,   per_s;
    logic          pv_r,    pv_s;
    logic          armed_r, armed_s;
    logic          ldir_r,  ldir_s;
    logic          stop_r,  stop_s;

    logic          gate_end_s;
    logic [VW-1:0] acc_sum_s;
    logic [PW-1:0] pcnt_inc_s;

    // Window-close detect and the accumulator including this cycle's step,
    // so a step in the final gate cycle lands in the closing window.
    always_comb begin
        gate_end_s = ena && (gcnt_r == GATE_END);
        acc_sum_s  = sat_step(acc_r, step & ena, dir);
        if (pcnt_r == PMAX) pcnt_inc_s = pcnt_r;
        else                pcnt_inc_s = pcnt_r + PW'(1);
    end

    // Next-state computation for the gate, velocity and period paths.
    always_comb begin
        gcnt_s  = gcnt_r;
        acc_s   = acc_r;
        vel_s   = vel_r;
        vv_s    = 1'b0;
        pcnt_s  = pcnt_r;
        per_s   = per_r;
        pv_s    = 1'b0;
        armed_s = armed_r;
        ldir_s  = ldir_r;
        stop_s  = stop_r;
        if (ena) begin
            if (gate_end_s) begin
                gcnt_s = '0;
                vel_s  = acc_sum_s;
                acc_s  = '0;
                vv_s   = 1'b1;
            end else begin
                gcnt_s = gcnt_r + GW'(1);
                acc_s  = acc_sum_s;
            end

            if (step) begin
                // A period is only meaningful between two same-direction
                // steps with no stall in between.
                if (armed_r && (dir == ldir_r) && !stop_r) begin
                    per_s = pcnt_r;
                    pv_s  = 1'b1;
                end else begin
                    per_s = per_r;
                end
                pcnt_s  = PW'(1);
                armed_s = 1'b1;
                ldir_s  = dir;
                stop_s  = 1'b0;
            end else begin
                pcnt_s = pcnt_inc_s;
                if (pcnt_inc_s == PMAX) begin
                    stop_s  = 1'b1;
                    armed_s = 1'b0;
                end else begin
                    stop_s  = stop_r;
                end
            end
        end else begin
            gcnt_s = gcnt_r;
        end
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt_r  <= '0;
            acc_r   <= '0;
            vel_r   <= '0;
            vv_r    <= 1'b0;
            pcnt_r  <= '0;
            per_r   <= '0;
            pv_r    <= 1'b0;
            armed_r <= 1'b0;
            ldir_r  <= 1'b1;
            stop_r  <= 1'b1;
        end else begin
            gcnt_r  <= gcnt_s;
            acc_r   <= acc_s;
            vel_r   <= vel_s;
            vv_r    <= vv_s;
            pcnt_r  <= pcnt_s;
            per_r   <= per_s;
            pv_r    <= pv_s;
            armed_r <= armed_s;
            ldir_r  <= ldir_s;
            stop_r  <= stop_s;
        end
    end

    assign vel          = vel_r;
    assign vel_valid    = vv_r;
    assign period       = per_r;
    assign period_valid = pv_r;
    assign stopped      = stop_r;

endmodule

// File: tb/tb_qei_velocity.sv
// Self-checking bench for qei_velocity with small parameters so windows,
// saturation and the stall timeout are all reached quickly.
module tb_qei_velocity;

    localparam int G    = 50;
    localparam int VW   = 6;
    localparam int PW   = 6;
    localparam int PMAX = (1 << PW) - 1;
    localparam int VHI  = (1 << (VW - 1)) - 1;
    localparam int VLO  = -(1 << (VW - 1));

    logic          clk = 1'b0;
    logic          rst, ena, step, dir;
    logic [VW-1:0] vel;
    logic          vel_valid;
    logic [PW-1:0] period;
    logic          period_valid;
    logic          stopped;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int m_pos, m_acc, m_ecnt;
    bit m_have, m_ldir;
    int x_vel, x_period;
    bit x_vv, x_pv;

    qei_velocity #(.GATE_CYCLES(G), .VW(VW), .PW(PW)) dut (
        .clk(clk), .rst(rst), .ena(ena), .step(step), .dir(dir),
        .vel(vel), .vel_valid(vel_valid), .period(period),
        .period_valid(period_valid), .stopped(stopped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        if (v > VHI) return VHI;
        if (v < VLO) return VLO;
        return v;
    endfunction

    // Model: running window count, cycles since last step, last direction.
    task automatic model_edge(input bit r, input bit e, input bit s, input bit d);
        if (r) begin
            m_pos = 0; m_acc = 0; m_ecnt = 0; m_have = 0; m_ldir = 1;
            x_vel = 0; x_vv = 0; x_period = 0; x_pv = 0;
        end else if (e) begin
            x_vv = 0; x_pv = 0;
            if (s) m_acc = clampv(m_acc + (d ? 1 : -1));
            if (m_pos == G - 1) begin
                x_vel = m_acc; x_vv = 1; m_acc = 0; m_pos = 0;
            end else begin
                m_pos++;
            end
            if (s) begin
                if (m_have && m_ecnt < PMAX && d == m_ldir) begin
                    x_period = m_ecnt; x_pv = 1;
                end
                m_have = 1; m_ecnt = 1; m_ldir = d;
            end else begin
                m_ecnt++;
            end
        end else begin
            x_vv = 0; x_pv = 0;
        end
    endtask

    // One clock: drive inputs, advance model, sample DUT 1 time unit after edge.
    task automatic cycle(input bit r, input bit e, input bit s, input bit d);
        rst = r; ena = e; step = s; dir = d;
        model_edge(r, e, s, d);
        @(posedge clk);
        #1;
        chk("vel",          int'($signed(vel)), x_vel);
        chk("vel_valid",    int'(vel_valid),    int'(x_vv));
        chk("period",       int'(period),       x_period);
        chk("period_valid", int'(period_valid), int'(x_pv));
        chk("stopped",      int'(stopped),      int'(!m_have || m_ecnt >= PMAX));
    endtask

    initial begin
        int p_step, p_dir, blk;
        rst = 1'b1; ena = 1'b0; step = 1'b0; dir = 1'b0;
        @(negedge clk);

        // Reset state
        cycle(1, 1, 1, 1);
        chk("rst_vel", int'(vel), 0);
        chk("rst_stopped", int'(stopped), 1);
        chk("rst_period", int'(period), 0);
        chk("rst_vv", int'(vel_valid), 0);

        // Step only in the final gate cycle (edge 50), another at edge 63
        for (int k = 1; k <= 49; k++) cycle(0, 1, 0, 1);
        cycle(0, 1, 1, 1);
        chk("final_cycle_vel", int'($signed(vel)), 1);
        chk("final_cycle_vv", int'(vel_valid), 1);
        chk("first_step_no_pv", int'(period_valid), 0);
        for (int k = 51; k <= 62; k++) cycle(0, 1, 0, 1);
        cycle(0, 1, 1, 1);
        chk("period_13", int'(period), 13);
        chk("period_13_pv", int'(period_valid), 1);
        for (int k = 64; k <= 100; k++) cycle(0, 1, 0, 1);
        chk("next_window_vel", int'($signed(vel)), 1);
        chk("next_window_vv", int'(vel_valid), 1);

        // Saturation both ways: step every cycle for a whole window
        for (int k = 101; k <= 150; k++) cycle(0, 1, 1, 1);
        chk("sat_pos", int'($signed(vel)), 31);
        chk("period_1", int'(period), 1);
        cycle(0, 1, 1, 0);
        chk("reversal_no_pv", int'(period_valid), 0);
        for (int k = 152; k <= 200; k++) cycle(0, 1, 1, 0);
        chk("sat_neg", int'($signed(vel)), -32);

        // Stall: 62 idle edges after a step -> stopped; next step no period
        for (int k = 0; k < 61; k++) cycle(0, 1, 0, 0);
        chk("not_yet_stopped", int'(stopped), 0);
        cycle(0, 1, 0, 0);
        chk("stopped_set", int'(stopped), 1);
        cycle(0, 1, 1, 0);
        chk("stall_step_no_pv", int'(period_valid), 0);
        chk("stall_step_clears", int'(stopped), 0);

        // Randomised blocks of varying step density, direction bias, ena, rst
        for (blk = 0; blk < 20; blk++) begin
            p_step = $urandom_range(0, 3);
            p_dir  = $urandom_range(0, 100);
            for (int k = 0; k < 200; k++) begin
                bit r, e, s, d;
                r = ($urandom_range(0, 399) == 0);
                e = ($urandom_range(0, 7) != 0);
                case (p_step)
                    0: s = 1'b1;
                    1: s = ($urandom_range(0, 1) == 0);
                    2: s = ($urandom_range(0, 7) == 0);
                    default: s = ($urandom_range(0, 79) == 0);
                endcase
                d = ($urandom_range(0, 99) < p_dir);
                cycle(r, e, s, d);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
